// File: rtl/mcu_uart_tx.sv
// UART transmitter toward the BL616 MCU: byte FIFO feeding an async framing engine
// with optional parity and one or two stop bits.
module mcu_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 48,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT) + ((STOP_BITS == 2) ? 1 : 0);

    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic              HAS_PAR   = (PARITY != 0);
    localparam logic              PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_c;
    logic             pop_c;
    logic             fifo_empty_c;
    logic [7:0]       fifo_head_c;

    assign ready        = (level_q != LVL_FULL) && !reset;
    assign push_c       = valid && ready;
    assign fifo_empty_c = (level_q == '0);
    assign fifo_head_c  = mem[rd_ptr_q];
    assign fifo_level   = level_q;

    // Storage array carries no reset; only pointers and level define contents.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Framing engine
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_n;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_n;
    logic [2:0]        bit_idx_q;
    logic [2:0]        bit_idx_n;
    logic [7:0]        byte_q;
    logic [7:0]        byte_n;
    logic              tx_q;
    logic              tx_n;
    logic              bit_done_c;
    logic              stop_done_c;

    assign bit_done_c  = (baud_q == BIT_LAST);
    assign stop_done_c = (baud_q == STOP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_n;
            baud_q    <= baud_n;
            bit_idx_q <= bit_idx_n;
            byte_q    <= byte_n;
            tx_q      <= tx_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        baud_n    = baud_q + BAUD_W'(1);
        bit_idx_n = bit_idx_q;
        byte_n    = byte_q;
        pop_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_n = '0;
                if (!fifo_empty_c) begin
                    pop_c     = 1'b1;
                    byte_n    = fifo_head_c;
                    bit_idx_n = '0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                if (bit_done_c) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done_c) begin
                    baud_n = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_n = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_n = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done_c) begin
                    baud_n  = '0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (stop_done_c) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty_c) begin
                        pop_c     = 1'b1;
                        byte_n    = fifo_head_c;
                        bit_idx_n = '0;
                        state_n   = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                baud_n  = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Line level is registered from the upcoming state so tx moves with the state change.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = byte_n[bit_idx_n];
            S_PARITY: tx_n = (^byte_n) ^ PAR_ODD;
            default:  tx_n = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE) || !fifo_empty_c;

endmodule

// File: tb/tb_mcu_uart_tx.sv
// Directed bench for mcu_uart_tx at CLKS_PER_BIT=4: single frame, back-to-back,
// FIFO fill, even/odd parity, two stop bits and reset mid-frame.
module tb_mcu_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] data_b;
    logic       valid_b;
    logic       ready_b;
    logic       tx_b;
    logic       busy_b;
    logic [4:0] level_b;

    logic [7:0] data_x;
    logic       valid_x;
    logic       ready_e, ready_o, ready_s;
    logic       tx_e, tx_o, tx_s;
    logic       busy_e, busy_o, busy_s;
    logic [4:0] level_e, level_o, level_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcu_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) u_base (
        .clk(clk), .reset(reset), .data(data_b), .valid(valid_b), .ready(ready_b),
        .tx(tx_b), .busy(busy_b), .fifo_level(level_b));

    mcu_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(reset), .data(data_x), .valid(valid_x), .ready(ready_e),
        .tx(tx_e), .busy(busy_e), .fifo_level(level_e));

    mcu_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(1)) u_odd (
        .clk(clk), .reset(reset), .data(data_x), .valid(valid_x), .ready(ready_o),
        .tx(tx_o), .busy(busy_o), .fifo_level(level_o));

    mcu_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .reset(reset), .data(data_x), .valid(valid_x), .ready(ready_s),
        .tx(tx_s), .busy(busy_s), .fifo_level(level_s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected line level k cycles after the start edge, 4 cycles per bit.
    function automatic logic frame_bit(input logic [7:0] b, input int k, input int par);
        int pos;
        pos = k / 4;
        if (k < 0)                 return 1'b1;
        if (pos == 0)              return 1'b0;
        if (pos <= 8)              return b[pos-1];
        if (pos == 9 && par == 1)  return ^b;
        if (pos == 9 && par == 2)  return ~(^b);
        return 1'b1;
    endfunction

    // Waits for a start bit on the base instance and samples each bit mid-window.
    task automatic decode(output logic [7:0] b, output int s);
        int t;
        t = 0;
        b = '0;
        while (tx_b !== 1'b0 && t < 200) begin
            tick();
            t++;
        end
        s = cyc;
        check("start_bit_seen", 32'(tx_b), 32'd0);
        repeat (5) tick();
        for (int i = 0; i < 8; i++) begin
            b[i] = tx_b;
            if (i < 7) repeat (4) tick();
        end
        repeat (4) tick();
        check("stop_bit", 32'(tx_b), 32'd1);
    endtask

    initial begin
        logic [7:0] b1, b2, fb;
        int         s1, s2, fs, p0, cnt;
        logic       acc;
        int         k, f;
        logic [7:0] xb;

        reset   = 1'b1;
        valid_b = 1'b0;
        data_b  = '0;
        valid_x = 1'b0;
        data_x  = '0;

        // Reset state
        repeat (2) tick();
        check("rst_tx", 32'(tx_b), 32'd1);
        check("rst_busy", 32'(busy_b), 32'd0);
        check("rst_level", 32'(level_b), 32'd0);
        check("rst_ready", 32'(ready_b), 32'd0);
        check("rst_ready_x", 32'({ready_e, ready_o, ready_s}), 32'd0);
        reset = 1'b0;
        #1;
        check("rel_ready", 32'(ready_b), 32'd1);
        tick();

        // Single byte 0x55, pushed at cycle 0
        valid_b = 1'b1;
        data_b  = 8'h55;
        check("single_ready", 32'(ready_b), 32'd1);
        tick();
        valid_b = 1'b0;
        check("single_c1_level", 32'(level_b), 32'd1);
        check("single_c1_busy", 32'(busy_b), 32'd1);
        check("single_c1_tx", 32'(tx_b), 32'd1);
        for (int c = 2; c <= 42; c++) begin
            tick();
            check("single_tx", 32'(tx_b), 32'(frame_bit(8'h55, c - 2, 0)));
            if (c == 2)  check("single_c2_level", 32'(level_b), 32'd0);
            if (c == 41) check("single_busy41", 32'(busy_b), 32'd1);
            if (c == 42) check("single_busy42", 32'(busy_b), 32'd0);
        end
        repeat (3) tick();

        // Back-to-back 0xA5, 0x3C
        p0      = cyc;
        valid_b = 1'b1;
        data_b  = 8'hA5;
        tick();
        data_b  = 8'h3C;
        tick();
        valid_b = 1'b0;
        decode(b1, s1);
        check("b2b_start_latency", 32'(s1 - p0), 32'd2);
        check("b2b_byte0", 32'(b1), 32'hA5);
        decode(b2, s2);
        check("b2b_gap", 32'(s2 - s1), 32'd40);
        check("b2b_byte1", 32'(b2), 32'h3C);
        repeat (3) tick();
        check("b2b_busy_end", 32'(busy_b), 32'd0);
        repeat (3) tick();

        // Fill: valid held high with incrementing data while the stream drains
        cnt = 0;
        fork
            begin
                valid_b = 1'b1;
                data_b  = 8'd0;
                for (int i = 0; i < 30; i++) begin
                    acc = ready_b;
                    tick();
                    if (acc) cnt++;
                    data_b = 8'(cnt);
                end
                check("fill_accepted", 32'(cnt), 32'd17);
                check("fill_ready", 32'(ready_b), 32'd0);
                check("fill_level", 32'(level_b), 32'd16);
                valid_b = 1'b0;
            end
            begin
                for (int j = 0; j < 17; j++) begin
                    decode(fb, fs);
                    check("fill_byte", 32'(fb), 32'(j));
                end
            end
        join
        repeat (3) tick();
        check("fill_busy_end", 32'(busy_b), 32'd0);
        check("fill_level_end", 32'(level_b), 32'd0);
        repeat (3) tick();

        // Parity and two stop bits: 0x07 then 0x80 on the other instances
        valid_x = 1'b1;
        data_x  = 8'h07;
        tick();
        data_x  = 8'h80;
        check("x_c1_tx", 32'({tx_e, tx_o, tx_s}), 32'h7);
        tick();
        valid_x = 1'b0;
        for (int c = 2; c <= 90; c++) begin
            if (c > 2) tick();
            k  = c - 2;
            f  = k / 44;
            xb = (f == 0) ? 8'h07 : 8'h80;
            if (f >= 2) begin
                check("even_tx", 32'(tx_e), 32'd1);
                check("odd_tx", 32'(tx_o), 32'd1);
                check("stop2_tx", 32'(tx_s), 32'd1);
            end else begin
                check("even_tx", 32'(tx_e), 32'(frame_bit(xb, k % 44, 1)));
                check("odd_tx", 32'(tx_o), 32'(frame_bit(xb, k % 44, 2)));
                check("stop2_tx", 32'(tx_s), 32'(frame_bit(xb, k % 44, 0)));
            end
            if (c == 89) check("x_busy89", 32'({busy_e, busy_o, busy_s}), 32'h7);
            if (c == 90) check("x_busy90", 32'({busy_e, busy_o, busy_s}), 32'h0);
        end
        repeat (3) tick();

        // Reset mid-frame: queue three bytes, reset during data bit 3
        valid_b = 1'b1;
        data_b  = 8'h11;
        tick();
        data_b  = 8'h22;
        tick();
        data_b  = 8'h33;
        tick();
        valid_b = 1'b0;
        for (int c = 4; c <= 19; c++) tick();
        check("mid_bit3", 32'(tx_b), 32'd0);
        check("mid_level", 32'(level_b), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_tx", 32'(tx_b), 32'd1);
        check("mid_level0", 32'(level_b), 32'd0);
        check("mid_busy0", 32'(busy_b), 32'd0);
        #1;
        check("mid_ready", 32'(ready_b), 32'd1);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("mid_quiet_tx", 32'(tx_b), 32'd1);
            check("mid_quiet_busy", 32'(busy_b), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
